spring_step_scheduler: RTL and testbench
========================================

// Module: spring_step_scheduler
// PURPOSE
//  Frame-level sequencer for the soft-body physics step. Per frame_start it runs
//  SUBSTEPS substeps. Each substep has two phases:
//   - launch the ideal-spring force unit and stream its per-node forces into the force buffer;
//   - latch the axle reaction force, pulse the integrator and wait for it to finish.
//  Sits between the frame timer and the spring-force unit / node integrator.
// PARAMETERS
//  NUM_NODES   10  nodes per body = force beats expected per substep
//  FORCE_SIZE  8   signed force width (spring unit outputs and buffer data)
//  SUBSTEPS    4   physics substeps per frame (>=1)
//  TIMEOUT     64  max cycles waiting in COLLECT or INTEGRATE before abort
// PORTS
//  clk_in          in   1                    system clock
//  rst_in          in   1                    synchronous active-high reset
//  frame_start     in   1                    pulse: begin a frame (ignored while busy)
//  springs_start   out  1                    1-cycle pulse to spring unit input_valid
//  spring_fx       in   FORCE_SIZE           signed per-node force x
//  spring_fy       in   FORCE_SIZE           signed per-node force y
//  spring_fvalid   in   1                    per-node force beat valid
//  spring_done     in   1                    spring unit output_valid (axle forces valid)
//  axle_fx_in      in   FORCE_SIZE           signed axle force x from spring unit
//  axle_fy_in      in   FORCE_SIZE           signed axle force y from spring unit
//  fbuf_we         out  1                    force buffer write enable
//  fbuf_addr       out  $clog2(NUM_NODES)    node index of the write
//  fbuf_wx         out  FORCE_SIZE           write data x
//  fbuf_wy         out  FORCE_SIZE           write data y
//  axle_fx         out  FORCE_SIZE           latched axle force x, current substep
//  axle_fy         out  FORCE_SIZE           latched axle force y, current substep
//  integ_start     out  1                    1-cycle pulse to node integrator
//  integ_done      in   1                    integrator finished pulse
//  substep_idx     out  $clog2(SUBSTEPS)+1   current substep index
//  busy            out  1                    high in any state except IDLE
//  frame_done      out  1                    1-cycle pulse: frame finished or aborted
//  err_count       out  1                    sticky: beat count != NUM_NODES at spring_done
//  err_timeout     out  1                    sticky: TIMEOUT expired and frame aborted
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0, including axle_fx/fy, substep_idx and both err flags.
//  States and transitions:
//   - IDLE: on frame_start, clear err flags, substep_idx=0, go to LAUNCH.
//   - LAUNCH (1 cycle): springs_start=1, beat_cnt=0, wait_cnt=0, go to COLLECT.
//       springs_start is high exactly 1 cycle after the accepted frame_start.
//   - COLLECT: on each spring_fvalid with beat_cnt<NUM_NODES, register one write:
//       fbuf_we=1 next cycle, fbuf_addr=beat_cnt, data=spring_fx/fy; then beat_cnt++.
//       Beats with beat_cnt>=NUM_NODES are dropped (no write) and set err_count.
//   - COLLECT on spring_done: latch axle_fx/fy and go to INTEGRATE. If beat_cnt
//       (including a same-cycle beat) != NUM_NODES, set err_count.
//       spring_fvalid and spring_done in the same cycle: the beat is written first.
//   - INTEGRATE: integ_start=1 on the first cycle only, then wait for integ_done.
//       integ_done in the integ_start cycle is accepted.
//   - INTEGRATE on integ_done: if substep_idx==SUBSTEPS-1 go to DONE; otherwise
//       substep_idx++ and go to LAUNCH.
//   - DONE (1 cycle): frame_done=1, go to IDLE.
//  Timeout:
//   - wait_cnt clears on entry to COLLECT and to INTEGRATE, increments every cycle there.
//   - wait_cnt==TIMEOUT-1 with no spring_done/integ_done: set err_timeout, pulse
//       frame_done, go to IDLE. axle_fx/fy hold their last value.
//  Inputs outside their phase: frame_start while busy, spring_* outside COLLECT and
//   integ_done outside INTEGRATE are ignored (no state or flag change).
//  rst_in mid-frame: aborts immediately, no frame_done pulse, all outputs go to reset values.
//  Widths: beat_cnt and wait_cnt are sized to hold NUM_NODES / TIMEOUT without wrap.
//   Force data is passed through unmodified; no arithmetic on forces.
// TESTING
//  1. Reset, frame_start; model returns 10 beats fx=i,fy=-i, then spring_done (axle 5,-3),
//     then integ_done 3 cycles after integ_start, all x4 substeps
//     -> 40 writes at addr 0..9 repeating, 4 springs_start, 4 integ_start,
//        axle_fx=5/axle_fy=-3, one frame_done, errs 0.
//  2. Substep with only 9 beats before spring_done -> err_count=1 and the frame still
//     completes; a 12-beat substep writes addr 0..9 only and sets err_count.
//  3. spring_done never arrives -> after 64 COLLECT cycles err_timeout=1, frame_done
//     pulse, busy=0.
//  4. frame_start pulsed mid-frame -> ignored (substep_idx unchanged, single frame_done);
//     next frame_start after done clears err flags.
//  5. rst_in high during INTEGRATE of substep 2 -> next cycle IDLE, all outputs 0,
//     no frame_done.
//  6. Same-cycle spring_fvalid+spring_done on the 10th beat, and integ_done coincident
//     with integ_start -> write at addr 9, err_count=0, substep advances.

Source files
------------

// File: rtl/spring_step_scheduler_if.sv
// ---------------------------------------------------------------------------
// spring_step_scheduler_if
//   Bundles every non-clock signal between the soft-body step scheduler and
//   its environment: the frame timer, the spring-force unit, the force
//   buffer and the node integrator.
//   master : scheduler side (drives springs_start, fbuf_*, axle_fx/fy,
//            integ_start, substep_idx, busy, frame_done, err_*).
//   slave  : environment side (drives frame_start, spring_*, axle_*_in,
//            integ_done).
// ---------------------------------------------------------------------------
interface spring_step_scheduler_if #(
  parameter int NUM_NODES  = 10,
  parameter int FORCE_SIZE = 8,
  parameter int SUBSTEPS   = 4
);
  localparam int AW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int SW = $clog2(SUBSTEPS) + 1;

  logic                         frame_start;
  logic                         springs_start;
  logic signed [FORCE_SIZE-1:0] spring_fx;
  logic signed [FORCE_SIZE-1:0] spring_fy;
  logic                         spring_fvalid;
  logic                         spring_done;
  logic signed [FORCE_SIZE-1:0] axle_fx_in;
  logic signed [FORCE_SIZE-1:0] axle_fy_in;
  logic                         fbuf_we;
  logic [AW-1:0]                fbuf_addr;
  logic signed [FORCE_SIZE-1:0] fbuf_wx;
  logic signed [FORCE_SIZE-1:0] fbuf_wy;
  logic signed [FORCE_SIZE-1:0] axle_fx;
  logic signed [FORCE_SIZE-1:0] axle_fy;
  logic                         integ_start;
  logic                         integ_done;
  logic [SW-1:0]                substep_idx;
  logic                         busy;
  logic                         frame_done;
  logic                         err_count;
  logic                         err_timeout;

  modport master (
    input  frame_start, spring_fx, spring_fy, spring_fvalid, spring_done,
           axle_fx_in, axle_fy_in, integ_done,
    output springs_start, fbuf_we, fbuf_addr, fbuf_wx, fbuf_wy,
           axle_fx, axle_fy, integ_start, substep_idx, busy, frame_done,
           err_count, err_timeout
  );

  modport slave (
    output frame_start, spring_fx, spring_fy, spring_fvalid, spring_done,
           axle_fx_in, axle_fy_in, integ_done,
    input  springs_start, fbuf_we, fbuf_addr, fbuf_wx, fbuf_wy,
           axle_fx, axle_fy, integ_start, substep_idx, busy, frame_done,
           err_count, err_timeout
  );
endinterface

// File: rtl/spring_step_scheduler.sv
// ---------------------------------------------------------------------------
// spring_step_scheduler
//   Frame-level sequencer for the soft-body physics step. Each accepted
//   frame_start runs SUBSTEPS substeps; a substep launches the spring-force
//   unit, streams its per-node forces into the force buffer, latches the
//   axle reaction force, then pulses the integrator and waits for it.
//   A per-phase watchdog aborts the frame if the spring unit or integrator
//   stalls for TIMEOUT cycles.
// Ports
//   clk_in : system clock
//   rst_in : synchronous active-high reset (aborts a frame silently)
//   bus    : spring_step_scheduler_if.master, all handshake/data signals
// ---------------------------------------------------------------------------
module spring_step_scheduler #(
  parameter int NUM_NODES  = 10,
  parameter int FORCE_SIZE = 8,
  parameter int SUBSTEPS   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  spring_step_scheduler_if.master bus
);

  localparam int AW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int BW = $clog2(NUM_NODES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SUBSTEPS) + 1;

  localparam logic [BW-1:0] NN    = BW'(NUM_NODES);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SLAST = SW'(SUBSTEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_COLLECT,
    S_INTEGRATE,
    S_DONE
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;

  logic [SW-1:0]                r_substep;
  logic [BW-1:0]                r_beat_cnt;
  logic [WW-1:0]                r_wait_cnt;
  logic                         r_fbuf_we;
  logic [AW-1:0]                r_fbuf_addr;
  logic signed [FORCE_SIZE-1:0] r_fbuf_wx;
  logic signed [FORCE_SIZE-1:0] r_fbuf_wy;
  logic signed [FORCE_SIZE-1:0] r_axle_fx;
  logic signed [FORCE_SIZE-1:0] r_axle_fy;
  logic                         r_err_count;
  logic                         r_err_timeout;
  logic                         r_abort;

  logic                         w_frame_accept;
  logic                         w_beat_ok;
  logic                         w_beat_drop;
  logic                         w_spring_end;
  logic                         w_integ_end;
  logic                         w_timeout;
  logic [BW-1:0]                w_beats_total;

  // Beat count as seen at spring_done, counting a beat accepted the same cycle.
  assign w_beats_total = r_beat_cnt + BW'(w_beat_ok);

  // ---- state register ----
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next state / control strobes ----
  always_comb begin
    w_state_nxt    = r_state;
    w_frame_accept = 1'b0;
    w_beat_ok      = 1'b0;
    w_beat_drop    = 1'b0;
    w_spring_end   = 1'b0;
    w_integ_end    = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.frame_start) begin
          w_frame_accept = 1'b1;
          w_state_nxt    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        w_beat_ok   = bus.spring_fvalid && (r_beat_cnt < NN);
        w_beat_drop = bus.spring_fvalid && !(r_beat_cnt < NN);
        if (bus.spring_done) begin
          w_spring_end = 1'b1;
          w_state_nxt  = S_INTEGRATE;
        end else if (r_wait_cnt == WLAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_INTEGRATE: begin
        if (bus.integ_done) begin
          w_integ_end = 1'b1;
          w_state_nxt = (r_substep == SLAST) ? S_DONE : S_LAUNCH;
        end else if (r_wait_cnt == WLAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- counters, flags and captured data ----
  // Every output must read zero out of reset, so the data registers are
  // cleared along with the control state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_substep     <= '0;
      r_beat_cnt    <= '0;
      r_wait_cnt    <= '0;
      r_fbuf_we     <= 1'b0;
      r_fbuf_addr   <= '0;
      r_fbuf_wx     <= '0;
      r_fbuf_wy     <= '0;
      r_axle_fx     <= '0;
      r_axle_fy     <= '0;
      r_err_count   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_abort       <= 1'b0;
    end else begin
      r_fbuf_we <= w_beat_ok;
      r_abort   <= w_timeout;

      if (w_frame_accept) begin
        r_substep <= '0;
      end else if (w_integ_end && (r_substep != SLAST)) begin
        r_substep <= r_substep + SW'(1);
      end

      if (r_state == S_LAUNCH) begin
        r_beat_cnt <= '0;
      end else if (w_beat_ok) begin
        r_beat_cnt <= r_beat_cnt + BW'(1);
      end

      // Watchdog restarts on entry to COLLECT and to INTEGRATE.
      if ((r_state == S_LAUNCH) || w_spring_end || w_integ_end) begin
        r_wait_cnt <= '0;
      end else if ((r_state == S_COLLECT) || (r_state == S_INTEGRATE)) begin
        r_wait_cnt <= r_wait_cnt + WW'(1);
      end

      if (w_beat_ok) begin
        r_fbuf_addr <= r_beat_cnt[AW-1:0];
        r_fbuf_wx   <= bus.spring_fx;
        r_fbuf_wy   <= bus.spring_fy;
      end

      if (w_spring_end) begin
        r_axle_fx <= bus.axle_fx_in;
        r_axle_fy <= bus.axle_fy_in;
      end

      if (w_frame_accept) begin
        r_err_count <= 1'b0;
      end else if (w_beat_drop || (w_spring_end && (w_beats_total != NN))) begin
        r_err_count <= 1'b1;
      end

      if (w_frame_accept) begin
        r_err_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  // ---- outputs ----
  assign bus.springs_start = (r_state == S_LAUNCH);
  // Watchdog is zero only on the first INTEGRATE cycle of a substep.
  assign bus.integ_start   = (r_state == S_INTEGRATE) && (r_wait_cnt == '0);
  assign bus.busy          = (r_state != S_IDLE);
  // An aborted frame reports completion one cycle after the timeout, from IDLE.
  assign bus.frame_done    = (r_state == S_DONE) || r_abort;
  assign bus.fbuf_we       = r_fbuf_we;
  assign bus.fbuf_addr     = r_fbuf_addr;
  assign bus.fbuf_wx       = r_fbuf_wx;
  assign bus.fbuf_wy       = r_fbuf_wy;
  assign bus.axle_fx       = r_axle_fx;
  assign bus.axle_fy       = r_axle_fy;
  assign bus.substep_idx   = r_substep;
  assign bus.err_count     = r_err_count;
  assign bus.err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_spring_step_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spring_step_scheduler
//   Directed bench for spring_step_scheduler. Expected force-buffer writes
//   are queued as beats are driven; a separate monitor pops one entry per
//   fbuf_we and compares. A second monitor counts control pulses.
// ---------------------------------------------------------------------------
module tb_spring_step_scheduler;

  localparam int NUM_NODES  = 10;
  localparam int FORCE_SIZE = 8;
  localparam int SUBSTEPS   = 4;
  localparam int TIMEOUT    = 64;

  typedef struct packed {
    logic [3:0]        addr;
    logic signed [7:0] wx;
    logic signed [7:0] wy;
  } wr_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n_ss;
  int   n_is;
  int   n_fd;
  wr_t  sb_q[$];

  spring_step_scheduler_if #(
    .NUM_NODES (NUM_NODES),
    .FORCE_SIZE(FORCE_SIZE),
    .SUBSTEPS  (SUBSTEPS)
  ) bus ();

  spring_step_scheduler #(
    .NUM_NODES (NUM_NODES),
    .FORCE_SIZE(FORCE_SIZE),
    .SUBSTEPS  (SUBSTEPS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every buffer write must match the oldest queued beat.
  initial begin : sb_monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.fbuf_we) begin
        if (sb_q.size() == 0) begin
          chk("fbuf_unexpected_we", 32'(bus.fbuf_addr), -32'sd1);
        end else begin
          e = sb_q.pop_front();
          chk("fbuf_addr", 32'(bus.fbuf_addr), 32'(e.addr));
          chk("fbuf_wx", 32'(bus.fbuf_wx), 32'(e.wx));
          chk("fbuf_wy", 32'(bus.fbuf_wy), 32'(e.wy));
        end
      end
    end
  end

  initial begin : pulse_monitor
    n_ss = 0;
    n_is = 0;
    n_fd = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.springs_start) n_ss++;
        if (bus.integ_start)   n_is++;
        if (bus.frame_done)    n_fd++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("springs_start_latency", 32'(bus.springs_start), 32'sd1);
  endtask

  // One substep: waits for springs_start, drives nbeats beats (fx=i, fy=-i),
  // spring_done (merged with the last beat when merge=1), then integ_done
  // idelay cycles after integ_start (idelay<0: leave it in INTEGRATE).
  task automatic do_substep(input int s, input int nbeats, input bit merge,
                            input int idelay, input int ax, input int ay,
                            input bit fs_pulse);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.springs_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("springs_start_seen", 32'(ok), 32'sd1);
    chk("substep_idx", 32'(bus.substep_idx), 32'(s));
    tick();
    for (int i = 0; i < nbeats; i++) begin
      bus.spring_fvalid = 1'b1;
      bus.spring_fx     = 8'(i);
      bus.spring_fy     = 8'(-i);
      if (fs_pulse && i == 0) bus.frame_start = 1'b1;
      if (i < NUM_NODES) sb_q.push_back('{addr: 4'(i), wx: 8'(i), wy: 8'(-i)});
      if (merge && i == nbeats - 1) begin
        bus.spring_done = 1'b1;
        bus.axle_fx_in  = 8'(ax);
        bus.axle_fy_in  = 8'(ay);
      end
      tick();
      bus.frame_start = 1'b0;
    end
    bus.spring_fvalid = 1'b0;
    if (!merge) begin
      bus.spring_done = 1'b1;
      bus.axle_fx_in  = 8'(ax);
      bus.axle_fy_in  = 8'(ay);
      tick();
    end
    bus.spring_done = 1'b0;
    bus.axle_fx_in  = '0;
    bus.axle_fy_in  = '0;
    chk("integ_start", 32'(bus.integ_start), 32'sd1);
    chk("axle_fx", 32'(bus.axle_fx), 32'(ax));
    chk("axle_fy", 32'(bus.axle_fy), 32'(ay));
    if (idelay >= 0) begin
      repeat (idelay) tick();
      bus.integ_done = 1'b1;
      tick();
      bus.integ_done = 1'b0;
    end
  endtask

  int fd0;
  int ss0;
  int is0;

  initial begin : stim
    n_tests = 0;
    n_fail  = 0;
    rst               = 1'b1;
    bus.frame_start   = 1'b0;
    bus.spring_fx     = '0;
    bus.spring_fy     = '0;
    bus.spring_fvalid = 1'b0;
    bus.spring_done   = 1'b0;
    bus.axle_fx_in    = '0;
    bus.axle_fy_in    = '0;
    bus.integ_done    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'sd0);
    chk("rst_springs_start", 32'(bus.springs_start), 32'sd0);
    chk("rst_fbuf_we", 32'(bus.fbuf_we), 32'sd0);
    chk("rst_axle_fx", 32'(bus.axle_fx), 32'sd0);
    chk("rst_substep", 32'(bus.substep_idx), 32'sd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'sd0);
    chk("rst_err_count", 32'(bus.err_count), 32'sd0);
    chk("rst_err_timeout", 32'(bus.err_timeout), 32'sd0);
    tick();

    // 1: nominal frame
    fd0 = n_fd; ss0 = n_ss; is0 = n_is;
    start_frame();
    for (int s = 0; s < SUBSTEPS; s++) do_substep(s, 10, 1'b0, 3, 5, -3, 1'b0);
    chk("t1_frame_done", 32'(bus.frame_done), 32'sd1);
    tick();
    chk("t1_busy_after", 32'(bus.busy), 32'sd0);
    chk("t1_frame_done_clr", 32'(bus.frame_done), 32'sd0);
    tick();
    chk("t1_springs_starts", 32'(n_ss - ss0), 32'sd4);
    chk("t1_integ_starts", 32'(n_is - is0), 32'sd4);
    chk("t1_frame_dones", 32'(n_fd - fd0), 32'sd1);
    chk("t1_err_count", 32'(bus.err_count), 32'sd0);
    chk("t1_err_timeout", 32'(bus.err_timeout), 32'sd0);
    chk("t1_sb_empty", 32'(sb_q.size()), 32'sd0);

    // 2a: short substep
    fd0 = n_fd;
    start_frame();
    do_substep(0, 9, 1'b0, 1, 5, -3, 1'b0);
    chk("t2a_err_count", 32'(bus.err_count), 32'sd1);
    for (int s = 1; s < SUBSTEPS; s++) do_substep(s, 10, 1'b0, 1, 5, -3, 1'b0);
    repeat (2) tick();
    chk("t2a_frame_dones", 32'(n_fd - fd0), 32'sd1);
    chk("t2a_err_count_end", 32'(bus.err_count), 32'sd1);

    // 2b: long substep, extra beats dropped
    start_frame();
    chk("t2b_err_cleared", 32'(bus.err_count), 32'sd0);
    do_substep(0, 12, 1'b0, 1, 2, 1, 1'b0);
    chk("t2b_err_count", 32'(bus.err_count), 32'sd1);
    for (int s = 1; s < SUBSTEPS; s++) do_substep(s, 10, 1'b0, 1, 2, 1, 1'b0);
    repeat (2) tick();
    chk("t2b_sb_empty", 32'(sb_q.size()), 32'sd0);

    // 3: spring_done never arrives
    start_frame();
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("t3_busy_before", 32'(bus.busy), 32'sd1);
    chk("t3_fd_before", 32'(bus.frame_done), 32'sd0);
    tick();
    chk("t3_frame_done", 32'(bus.frame_done), 32'sd1);
    chk("t3_busy", 32'(bus.busy), 32'sd0);
    chk("t3_err_timeout", 32'(bus.err_timeout), 32'sd1);
    chk("t3_axle_hold", 32'(bus.axle_fx), 32'sd2);
    tick();
    chk("t3_frame_done_clr", 32'(bus.frame_done), 32'sd0);

    // 4: frame_start mid-frame ignored; new frame clears flags
    fd0 = n_fd;
    start_frame();
    chk("t4_err_timeout_clr", 32'(bus.err_timeout), 32'sd0);
    do_substep(0, 10, 1'b0, 2, 5, -3, 1'b1);
    for (int s = 1; s < SUBSTEPS; s++) do_substep(s, 10, 1'b0, 2, 5, -3, 1'b0);
    repeat (2) tick();
    chk("t4_frame_dones", 32'(n_fd - fd0), 32'sd1);
    chk("t4_busy", 32'(bus.busy), 32'sd0);

    // 5: reset during INTEGRATE of substep 2
    fd0 = n_fd;
    start_frame();
    do_substep(0, 10, 1'b0, 1, 4, -4, 1'b0);
    do_substep(1, 10, 1'b0, 1, 4, -4, 1'b0);
    do_substep(2, 10, 1'b0, -1, 4, -4, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("t5_busy", 32'(bus.busy), 32'sd0);
    chk("t5_substep", 32'(bus.substep_idx), 32'sd0);
    chk("t5_axle_fx", 32'(bus.axle_fx), 32'sd0);
    chk("t5_axle_fy", 32'(bus.axle_fy), 32'sd0);
    chk("t5_integ_start", 32'(bus.integ_start), 32'sd0);
    chk("t5_frame_done", 32'(bus.frame_done), 32'sd0);
    chk("t5_fbuf_wx", 32'(bus.fbuf_wx), 32'sd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("t5_no_frame_done", 32'(n_fd - fd0), 32'sd0);
    chk("t5_idle", 32'(bus.busy), 32'sd0);

    // 6: merged last beat + spring_done, integ_done with integ_start
    fd0 = n_fd;
    start_frame();
    for (int s = 0; s < SUBSTEPS; s++) do_substep(s, 10, 1'b1, 0, -7, 6, 1'b0);
    chk("t6_frame_done", 32'(bus.frame_done), 32'sd1);
    chk("t6_err_count", 32'(bus.err_count), 32'sd0);
    repeat (2) tick();
    chk("t6_frame_dones", 32'(n_fd - fd0), 32'sd1);
    chk("t6_sb_empty", 32'(sb_q.size()), 32'sd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
